// File: rtl/fifo_serializer_pkg.sv
// Shared definitions for the FIFO read-side serializer: FSM state encodings
// and default frame geometry. Used by fifo_serializer and its bench.
package fifo_serializer_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } state_e;

endpackage

// File: rtl/fifo_serializer_baud_tick_gen.sv
// Bit-period timer. tick is high on the last cycle of every bit period;
// clear forces the next cycle to be the first cycle of a fresh period.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   // Count 0..CLKS_PER_BIT-1, wrapping on the bit boundary or on clear.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   // Period counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_serializer.sv
// FIFO read-side serializer: pops show-ahead FIFO words and shifts them out
// as start bit, LSB-first data, optional even parity, stop bit.
// Optional parity bit is enabled by defining FIFO_SERIALIZER_PARITY_EN.
// Outputs are registered from the current state, so tx/busy trail the FSM
// by one cycle; rd_val seen in IDLE in cycle N drops tx in cycle N+2.
module fifo_serializer
   import fifo_serializer_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_val,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic                  tx,
   output logic                  busy
);

   localparam int IDX_W = $clog2(DATA_WIDTH + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   state_e                state_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [IDX_W-1:0]      bit_idx_q;
   logic                  par_q;
   logic                  tx_q;
   logic                  rd_en_q;
   logic                  busy_q;
   logic                  tick;
   logic                  start_frame;

   // A frame starts from IDLE, or straight out of the last STOP cycle so
   // back-to-back words leave no idle gap. The pop strobe follows one cycle
   // later, which also keeps it from ever being high on consecutive cycles.
   assign start_frame = rd_val && ((state_q == IDLE) || ((state_q == STOP) && tick));

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .reset(reset),
      .clear(start_frame),
      .tick (tick)
   );

   assign rd_en = rd_en_q;
   assign tx    = tx_q;
   assign busy  = busy_q;

   // Frame FSM with registered line, busy and pop outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         rd_en_q <= start_frame;
         busy_q  <= (state_q != IDLE);

         case (state_q)
            START:   tx_q <= 1'b0;
            DATA:    tx_q <= shreg_q[0];
            PARITY:  tx_q <= par_q;
            default: tx_q <= 1'b1;
         endcase

         if (start_frame) begin
            shreg_q   <= rd_data;
            par_q     <= ^rd_data;
            bit_idx_q <= '0;
            state_q   <= START;
         end else if (tick) begin
            case (state_q)
               START: begin
                  bit_idx_q <= '0;
                  state_q   <= DATA;
               end
               DATA: begin
                  shreg_q   <= shreg_q >> 1;
                  bit_idx_q <= bit_idx_q + IDX_W'(1);
                  if (bit_idx_q == IDX_LAST) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end
               PARITY:  state_q <= STOP;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer (DATA_WIDTH=8, CLKS_PER_BIT=4).
// Honours FIFO_SERIALIZER_PARITY_EN for the frame length and parity bit.
module tb_fifo_serializer;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef FIFO_SERIALIZER_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic          clk     = 1'b0;
   logic          reset   = 1'b1;
   logic          rd_val  = 1'b0;
   logic [DW-1:0] rd_data = '0;
   logic          rd_en;
   logic          tx;
   logic          busy;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic          tx_log[$];
   logic          en_log[$];
   logic          busy_log[$];
   logic          pop_pend = 1'b0;

   always #5 clk = ~clk;

   fifo_serializer #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .rd_val (rd_val),
      .rd_data(rd_data),
      .rd_en  (rd_en),
      .tx     (tx),
      .busy   (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive_fifo();
      rd_val  = (fifo_q.size() > 0);
      rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
   endtask

   // One clock: apply the pop decided by the previous cycle, refresh the
   // show-ahead head, then sample outputs at the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
      @(negedge clk);
      pop_pend = rd_en && rd_val;
   endtask

   task automatic clear_logs();
      tx_log.delete();
      en_log.delete();
      busy_log.delete();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         cyc();
         tx_log.push_back(tx);
         en_log.push_back(rd_en);
         busy_log.push_back(busy);
      end
   endtask

   function automatic int ones(input logic q[$]);
      int n = 0;
      foreach (q[k]) if (q[k] === 1'b1) n++;
      return n;
   endfunction

   // Frame image: start 0, data LSB first, optional even parity, stop 1.
   task automatic check_frame(input int s, input logic [7:0] b, input string tag);
      logic       e;
      logic [3:0] o;
      for (int i = 0; i < NBITS; i++) begin
         if (i == 0) e = 1'b0;
         else if (i <= DW) e = b[i-1];
         else if (NBITS == 11 && i == DW + 1) e = ^b;
         else e = 1'b1;
         for (int c = 0; c < CPB; c++) o[c] = tx_log[s + i*CPB + c];
         chk($sformatf("%s_bit%0d", tag, i), {28'd0, o}, {28'd0, {4{e}}});
      end
   endtask

   initial begin
      logic [10:0] exp51;
`ifdef FIFO_SERIALIZER_PARITY_EN
      exp51 = 11'b110_1010_0010;
`else
      exp51 = 11'b010_1010_0010;
`endif

      // Reset held two cycles with a word waiting.
      fifo_q.push_back(8'hA5);
      drive_fifo();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("rst_tx", tx, 1);
         chk("rst_rd_en", rd_en, 0);
         chk("rst_busy", busy, 0);
      end
      fifo_q.delete();
      drive_fifo();
      cyc();
      reset = 1'b0;

      // Single word 0x51.
      clear_logs();
      fifo_q.push_back(8'h51);
      drive_fifo();
      run(FRAME_CYC + 20);
      chk("single_rd_en_first", en_log[0], 1);
      chk("single_rd_en_count", ones(en_log), 1);
      chk("single_tx_before_start", tx_log[0], 1);
      for (int i = 0; i < NBITS; i++) begin
         logic [3:0] o;
         for (int c = 0; c < CPB; c++) o[c] = tx_log[1 + i*CPB + c];
         chk($sformatf("single_level%0d", i), {28'd0, o}, {28'd0, {4{exp51[i]}}});
      end
      chk("single_busy_len", ones(busy_log), FRAME_CYC);
      chk("single_busy_pre", busy_log[0], 0);
      chk("single_busy_post", busy_log[FRAME_CYC + 1], 0);
      chk("single_tx_idle_after", tx_log[FRAME_CYC + 5], 1);
`ifdef FIFO_SERIALIZER_PARITY_EN
      chk("parity_51", tx_log[1 + 9*CPB], 1);
`endif

      // Back-to-back: four preloaded words.
      clear_logs();
      fifo_q = '{8'd81, 8'd99, 8'd141, 8'd250};
      exp_q  = '{8'd81, 8'd99, 8'd141, 8'd250};
      drive_fifo();
      run(4*FRAME_CYC + 20);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("b2b_rd_en%0d", k), en_log[k*FRAME_CYC], 1);
         check_frame(1 + k*FRAME_CYC, exp_q.pop_front(), $sformatf("b2b_f%0d", k));
      end
      chk("b2b_rd_en_count", ones(en_log), 4);
      chk("b2b_busy_len", ones(busy_log), 4*FRAME_CYC);
      chk("b2b_fifo_drained", fifo_q.size(), 0);
`ifdef FIFO_SERIALIZER_PARITY_EN
      chk("parity_63", tx_log[1 + FRAME_CYC + 9*CPB], 0);
`endif

      // Empty FIFO for 100 cycles.
      clear_logs();
      run(100);
      chk("empty_rd_en", ones(en_log), 0);
      chk("empty_tx_high", ones(tx_log), 100);
      chk("empty_busy", ones(busy_log), 0);

      // Reset during DATA bit 3 of 0xFA; next frame must carry 0x33.
      clear_logs();
      fifo_q = '{8'hFA, 8'h33};
      drive_fifo();
      run(18);
      chk("midrst_rd_en", en_log[0], 1);
      chk("midrst_bit3", tx_log[17], 1);
      chk("midrst_in_frame", busy_log[17], 1);
      reset = 1'b1;
      cyc();
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_en_low", rd_en, 0);
      reset = 1'b0;
      clear_logs();
      run(FRAME_CYC + 10);
      chk("after_rst_rd_en", en_log[0], 1);
      check_frame(1, 8'h33, "after_rst");
      chk("after_rst_fifo_drained", fifo_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
